decoder_hold: RTL and testbench

- Registered 3-to-8 one-hot decoder: the write side of the index/one-hot interface whose read side is the combinational 8-to-3 encoder.
- Accepts binary indices over a valid/ready handshake and buffers them in a small FIFO.
- Drives each decoded one-hot word for a programmable number of cycles before advancing, for row/LED select and the strobe-generation paths.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decoder_hold_sync_fifo.sv | 61 ++++++
 rtl/decoder_hold.sv | 110 +++++++++++
 tb/tb_decoder_hold.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the registered index-to-one-hot decoder.
package decoder_pkg;

    localparam int unsigned IN_W_DEF  = 3;
    localparam int unsigned OUT_W_DEF = 1 << IN_W_DEF;

    typedef enum logic {
        StIdle  = 1'b0,
        StDrive = 1'b1
    } state_e;

    // Binary index to one-hot word; also used by encoder self-check benches.
    function automatic logic [OUT_W_DEF-1:0] onehot(input logic [IN_W_DEF-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/decoder_hold_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers and a synchronous flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers share the low bits when full or empty; the top bit tells them apart.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign dout    = mem_q[rd_q[AW-1:0]];

    // Pointer next-state: flush wins over any push or pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/decoder_hold.sv
// Registered one-hot decoder: buffers indices and drives each word for HOLD cycles.
module decoder_hold
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned HOLD  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_idx,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(HOLD - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]  onehot_q, onehot_d;
    logic              last_q, last_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [IN_W-1:0]   fifo_dout;

    // in_ready looks only at registered full, never at a same-cycle pop.
    assign in_ready   = !fifo_full && !clr;
    assign out_onehot = onehot_q;
    assign out_valid  = (state_q == StDrive);
    assign out_last   = last_q;
    assign busy       = !fifo_empty || out_valid;

    sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (in_valid && in_ready),
        .pop   (fifo_pop),
        .din   (in_idx),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state: load a word when idle or at hold expiry, else count down.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        fifo_pop = 1'b0;
        if (clr) begin
            state_d  = StIdle;
            cnt_d    = '0;
            onehot_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        onehot_d = OUT_W'(1) << fifo_dout;
                        cnt_d    = CntLoad;
                        state_d  = StDrive;
                    end
                end
                StDrive: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else if (!fifo_empty) begin
                        // Back-to-back load keeps out_onehot free of a zero gap.
                        fifo_pop = 1'b1;
                        onehot_d = OUT_W'(1) << fifo_dout;
                        cnt_d    = CntLoad;
                    end else begin
                        onehot_d = '0;
                        state_d  = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        last_d = (state_d == StDrive) && (cnt_d == '0);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            onehot_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_decoder_hold.sv
// Bench: two decoders (HOLD=4 and HOLD=1) on shared stimulus against a queue model.
module tb_decoder_hold;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx = '0;

    logic       g_rdy  [2];
    logic [7:0] g_oh   [2];
    logic       g_vld  [2];
    logic       g_last [2];
    logic       g_busy [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending indices plus the word on the output and its remaining cycles.
    int hold_of [2] = '{4, 1};
    int m_buf   [2][DEPTH];
    int m_cnt   [2];
    int m_head  [2];
    int m_cur   [2];
    int m_rem   [2];
    bit m_act   [2];
    bit m_acc   [2];

    always #5 clk = ~clk;

    decoder_hold #(.IN_W(3), .OUT_W(8), .HOLD(4), .DEPTH(DEPTH)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (g_rdy[0]),
        .in_idx     (in_idx),
        .out_onehot (g_oh[0]),
        .out_valid  (g_vld[0]),
        .out_last   (g_last[0]),
        .busy       (g_busy[0])
    );

    decoder_hold #(.IN_W(3), .OUT_W(8), .HOLD(1), .DEPTH(DEPTH)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (g_rdy[1]),
        .in_idx     (in_idx),
        .out_onehot (g_oh[1]),
        .out_valid  (g_vld[1]),
        .out_last   (g_last[1]),
        .busy       (g_busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_head[d] = 0;
            m_act[d]  = 1'b0;
            m_rem[d]  = 0;
            m_acc[d]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = in_valid && !clr && (m_cnt[d] < DEPTH);
            if (rst) begin
                m_cnt[d] = 0; m_head[d] = 0; m_act[d] = 1'b0; m_acc[d] = 1'b0;
            end else if (clr) begin
                m_cnt[d] = 0; m_head[d] = 0; m_act[d] = 1'b0;
            end else begin
                if (m_act[d]) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) m_act[d] = 1'b0;
                end
                if (!m_act[d] && m_cnt[d] > 0) begin
                    m_cur[d]  = m_buf[d][m_head[d]];
                    m_head[d] = (m_head[d] + 1) % DEPTH;
                    m_cnt[d]--;
                    m_act[d]  = 1'b1;
                    m_rem[d]  = hold_of[d];
                end
                if (m_acc[d]) begin
                    m_buf[d][(m_head[d] + m_cnt[d]) % DEPTH] = int'(in_idx);
                    m_cnt[d]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic [7:0] exp_oh;
            exp_oh = m_act[d] ? (8'd1 << m_cur[d]) : 8'd0;
            check($sformatf("onehot[h%0d]", hold_of[d]), 32'(g_oh[d]), 32'(exp_oh));
            check($sformatf("valid[h%0d]", hold_of[d]), 32'(g_vld[d]), 32'(m_act[d]));
            check($sformatf("last[h%0d]", hold_of[d]), 32'(g_last[d]),
                  32'(m_act[d] && m_rem[d] == 1));
            check($sformatf("busy[h%0d]", hold_of[d]), 32'(g_busy[d]),
                  32'(m_act[d] || m_cnt[d] > 0));
            check($sformatf("ready[h%0d]", hold_of[d]), 32'(g_rdy[d]),
                  32'((m_cnt[d] < DEPTH) && !clr));
            if (g_vld[d]) check($sformatf("popcount[h%0d]", hold_of[d]),
                                32'($countones(g_oh[d])), 32'd1);
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic push(input int idx);
        in_valid = 1'b1;
        in_idx   = 3'(idx);
        cycle();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        clr      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!g_busy[0] && !g_busy[1]) break;
            cycle();
        end
        check("drain_timeout", 32'(g_busy[0] || g_busy[1]), 32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        rst = 1'b0;
        #1;
        compare_all();

        // Single index 5.
        push(5);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        check("single_busy", 32'(g_busy[0]), 32'd0);

        // Back-to-back 0..3, then full boundary 7..2 held until accepted.
        for (int i = 0; i < 4; i++) push(i);
        for (int i = 7; i >= 2; i--) begin
            int tries = 0;
            in_valid = 1'b1;
            in_idx   = 3'(i);
            do begin
                cycle();
                tries++;
            end while (!m_acc[0] && tries < 40);
            check("full_accept_timeout", 32'(m_acc[0]), 32'd1);
        end
        drain();

        // Exhaustive walk for HOLD=1.
        for (int i = 0; i < 8; i++) push(i);
        drain();

        // Flush during the second cycle of word 3.
        push(3);
        push(4);
        push(5);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_idx   = 3'd6;
        cycle();
        check("flush_onehot", 32'(g_oh[0]), 32'd0);
        check("flush_busy", 32'(g_busy[0]), 32'd0);
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Async reset mid-DRIVE with two entries queued.
        push(1);
        push(2);
        push(3);
        in_valid = 1'b0;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_onehot", 32'(g_oh[0]), 32'd0);
        check("arst_valid", 32'(g_vld[0]), 32'd0);
        check("arst_last", 32'(g_last[0]), 32'd0);
        model_reset();
        cycle();
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check("arst_ready", 32'(g_rdy[0]), 32'd1);
        for (int i = 0; i < 5; i++) cycle();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 800; i++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_idx   = 3'($urandom_range(0, 7));
            clr      = ($urandom_range(0, 39) == 0);
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
